mem_wb_stage: RTL and testbench
===============================

// Module: mem_wb_stage
// PURPOSE
//  MEM/WB pipeline stage feeding the register file's write port (reg_write/wdata/write).
//  Takes the EX/MEM result and waits on a variable-latency data memory for loads.
//  Extracts and extends load bytes/halves and selects ALU/load/link data.
//  Registers one writeback per retired instruction; the register file's same-cycle bypass covers WB->ID.
// PARAMETERS
//  MEM_TIMEOUT  16  max cycles a load waits in WAIT_MEM before abort (>=1)
//  BIG_ENDIAN   0   0: byte 0 at addr[1:0]=0 is rdata[7:0]; 1: byte 0 is rdata[31:24]
// PORTS
//  clk         in   1   rising-edge clock
//  rst_n       in   1   async active-low reset
//  ex_valid    in   1   EX/MEM slot holds a live instruction
//  ex_alu      in   32  ALU result / load address
//  ex_rd       in   5   destination register
//  ex_regwr    in   1   instruction writes rd
//  ex_load     in   3   0 none, 1 LW, 2 LH, 3 LHU, 4 LB, 5 LBU (6,7 treated as none)
//  ex_link     in   1   JAL/JALR: write ex_pc8
//  ex_pc8      in   32  PC+8
//  flush       in   1   kill the current EX/MEM instruction
//  mem_rdata   in   32  data memory read word (word-aligned)
//  mem_ready   in   1   mem_rdata valid this cycle
//  stall       out  1   upstream must hold the EX/MEM inputs stable
//  reg_write   out  5   register file write address
//  wdata       out  32  register file write data
//  write       out  1   register file write enable
//  mem_err     out  1   1-cycle pulse: load timed out
//  misalign    out  1   1-cycle pulse: misaligned load dropped
//  retired     out  32  count of instructions completed (written or not)
// BEHAVIOUR
//  Reset: all outputs 0, FSM=RUN, wait counter=0; async assert, sync release.
//  FSM RUN:
//   - ex_valid & !flush & load & !mem_ready -> WAIT_MEM; stall=1 comb.
//   - Otherwise capture at the edge, except misaligned loads (below).
//  FSM WAIT_MEM:
//   - stall=1 while !mem_ready & !flush & cnt<MEM_TIMEOUT; cnt increments each cycle.
//   - mem_ready -> capture, return to RUN; stall=0 that cycle.
//   - cnt==MEM_TIMEOUT -> drop instruction; mem_err=1 next cycle; stall=0; -> RUN.
//   - flush (priority over mem_ready, timeout) -> drop, no err, -> RUN.
//  Load alignment (ex_alu[1:0]):
//   - LW needs 00; LH/LHU need bit0=0.
//   - Misaligned: no write, misalign=1 next cycle, retired++, no wait for memory.
//  Load extraction: pick the byte/half per addr and BIG_ENDIAN.
//   - LH/LB sign-extend; LHU/LBU zero-extend.
//  Data select priority: ex_link -> ex_pc8; load -> extracted; else ex_alu.
//  Capture (edge):
//   - reg_write<=ex_rd; wdata<=selected.
//   - write<=ex_regwr & (ex_rd!=0).
//   - retired++ (wraps at 2^32-1 -> 0).
//   - Latency: 1 cycle after the accept cycle.
//  Non-capture cycles: write<=0; reg_write/wdata hold last value.
//  Flush in RUN: no capture; write<=0; retired unchanged.
//  ex_valid=0: bubble; write<=0.
//  mem_ready outside a waiting load is ignored.
//  stall is combinational from ex_valid, ex_load, mem_ready, flush, FSM, cnt.
// TESTING
//  ADDU: ex_rd=8, ex_alu=0x1234 -> next cycle write=1, reg_write=8, wdata=0x1234, retired=1.
//  LB 1: ex_alu=...03, rdata=0x80FF_FF7F, BE=0 -> wdata=0xFFFF_FF80.
//  LBU: same word, addr[1:0]=0 -> wdata=0x7F.
//  Wait: mem_ready low 3 cycles -> stall high 3 cycles; write the cycle after ready.
//  Timeout: MEM_TIMEOUT=4, ready never -> stall 4 cycles; mem_err pulse; write stays 0.
//  Edge cases:
//   - LW at ...02 -> misalign pulse, no write.
//   - rd=0 -> write=0.
//   - flush during WAIT_MEM -> no write, no err.
//   - rst_n low mid-wait -> all outputs 0 at once.

Source files
------------

// File: rtl/mem_wb_stage.sv
// MEM/WB stage: waits on a variable-latency data memory for loads, extracts and extends
// load data, and registers one register-file write per retired instruction.
module mem_wb_stage #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter bit          BIG_ENDIAN  = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [31:0] ex_alu,
  input  logic [4:0]  ex_rd,
  input  logic        ex_regwr,
  input  logic [2:0]  ex_load,
  input  logic        ex_link,
  input  logic [31:0] ex_pc8,
  input  logic        flush,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        stall,
  output logic [4:0]  reg_write,
  output logic [31:0] wdata,
  output logic        write,
  output logic        mem_err,
  output logic        misalign,
  output logic [31:0] retired
);

  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [2:0] LD_W  = 3'd1;
  localparam logic [2:0] LD_H  = 3'd2;
  localparam logic [2:0] LD_HU = 3'd3;
  localparam logic [2:0] LD_B  = 3'd4;
  localparam logic [2:0] LD_BU = 3'd5;

  typedef enum logic {RUN, WAIT_MEM} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               capture, retire_only, err_n;
  logic               is_load, is_misaligned;
  logic [1:0]         byte_idx;
  logic               half_idx;
  logic [7:0]         ld_byte;
  logic [15:0]        ld_half;
  logic [31:0]        ld_data, sel_data;

  assign is_load       = (ex_load >= LD_W) && (ex_load <= LD_BU);
  assign is_misaligned = ((ex_load == LD_W) && (ex_alu[1:0] != 2'b00)) ||
                         (((ex_load == LD_H) || (ex_load == LD_HU)) && ex_alu[0]);

  // Byte/half lane selection follows the memory's byte ordering
  always_comb begin
    byte_idx = BIG_ENDIAN ? 2'(2'd3 - ex_alu[1:0]) : ex_alu[1:0];
    half_idx = ex_alu[1] ^ BIG_ENDIAN;
    ld_byte  = mem_rdata[{byte_idx, 3'b000} +: 8];
    ld_half  = mem_rdata[{half_idx, 4'b0000} +: 16];
    case (ex_load)
      LD_W:    ld_data = mem_rdata;
      LD_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      LD_HU:   ld_data = {16'h0000, ld_half};
      LD_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      LD_BU:   ld_data = {24'h000000, ld_byte};
      default: ld_data = ex_alu;
    endcase
    if (ex_link)      sel_data = ex_pc8;
    else if (is_load) sel_data = ld_data;
    else              sel_data = ex_alu;
  end

  // Next-state, stall and retirement decisions
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    stall       = 1'b0;
    capture     = 1'b0;
    retire_only = 1'b0;
    err_n       = 1'b0;
    case (state)
      RUN: begin
        if (ex_valid && !flush) begin
          if (is_load && is_misaligned) begin
            retire_only = 1'b1;
          end else if (is_load && !mem_ready) begin
            stall   = 1'b1;
            state_n = WAIT_MEM;
            cnt_n   = CNT_W'(1);
          end else begin
            capture = 1'b1;
          end
        end
      end
      WAIT_MEM: begin
        if (flush) begin
          state_n = RUN;
          cnt_n   = '0;
        end else if (mem_ready) begin
          capture = 1'b1;
          state_n = RUN;
          cnt_n   = '0;
        end else if (cnt >= CNT_W'(MEM_TIMEOUT)) begin
          err_n   = 1'b1;
          state_n = RUN;
          cnt_n   = '0;
        end else begin
          stall = 1'b1;
          cnt_n = CNT_W'(cnt + CNT_W'(1));
        end
      end
      default: begin
        state_n = RUN;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Writeback port and status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write <= '0;
      wdata     <= '0;
      write     <= 1'b0;
      mem_err   <= 1'b0;
      misalign  <= 1'b0;
      retired   <= '0;
    end else begin
      write    <= capture && ex_regwr && (ex_rd != 5'd0);
      mem_err  <= err_n;
      misalign <= retire_only;
      if (capture) begin
        reg_write <= ex_rd;
        wdata     <= sel_data;
      end
      if (capture || retire_only) retired <= retired + 32'd1;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized bench for mem_wb_stage: each instruction is predicted as a whole transaction
// (stall length, outcome, written data) by a memory-view reference model.
module tb_mem_wb_stage;
  localparam int unsigned TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_regwr, ex_link, flush, mem_ready;
  logic [31:0] ex_alu, ex_pc8, mem_rdata;
  logic [4:0]  ex_rd;
  logic [2:0]  ex_load;
  logic        stall, write, mem_err, misalign;
  logic [4:0]  reg_write;
  logic [31:0] wdata, retired;

  int n_checks = 0;
  int n_pass   = 0;

  logic [4:0]  m_rd;
  logic [31:0] m_wdata, m_ret;

  mem_wb_stage #(.MEM_TIMEOUT(TMO), .BIG_ENDIAN(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_alu(ex_alu), .ex_rd(ex_rd),
    .ex_regwr(ex_regwr), .ex_load(ex_load), .ex_link(ex_link), .ex_pc8(ex_pc8),
    .flush(flush), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .stall(stall),
    .reg_write(reg_write), .wdata(wdata), .write(write), .mem_err(mem_err),
    .misalign(misalign), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Little-endian memory view: byte i of the word lives at address offset i
  function automatic logic [31:0] extract(input logic [2:0] ld, input logic [1:0] a,
                                          input logic [31:0] word);
    logic [7:0] mem [4];
    logic [15:0] h;
    for (int i = 0; i < 4; i++) mem[i] = 8'(word >> (8 * i));
    h = {mem[a | 2'd1], mem[a & 2'd2]};
    case (ld)
      3'd1: return word;
      3'd2: return {{16{h[15]}}, h};
      3'd3: return {16'h0, h};
      3'd4: return {{24{mem[a][7]}}, mem[a]};
      3'd5: return {24'h0, mem[a]};
      default: return 32'hX;
    endcase
  endfunction

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_write"}, 32'(write), 32'd0);
    check_eq({tag, "_reg_write"}, 32'(reg_write), 32'd0);
    check_eq({tag, "_wdata"}, wdata, 32'd0);
    check_eq({tag, "_retired"}, retired, 32'd0);
    check_eq({tag, "_mem_err"}, 32'(mem_err), 32'd0);
    check_eq({tag, "_misalign"}, 32'(misalign), 32'd0);
  endtask

  // lat: cycles until mem_ready rises; fl_at: cycle index at which flush pulses (-1 none)
  task automatic do_instr(input logic v, input logic [31:0] alu, input logic [4:0] rd,
                          input logic regwr, input logic [2:0] ld, input logic lnk,
                          input logic [31:0] pc8, input int lat, input int fl_at,
                          input logic [31:0] rdata);
    bit live, is_ld, mis, exp_write, exp_err, exp_mis;
    int e, outcome;
    live  = v && (fl_at != 0);
    is_ld = (ld >= 3'd1) && (ld <= 3'd5);
    mis   = is_ld && (((ld == 3'd1) && (alu[1:0] != 2'b00)) ||
                      (((ld == 3'd2) || (ld == 3'd3)) && alu[0]));
    e = 0;
    outcome = 0;  // 0 dropped, 1 captured, 2 timed out, 3 misaligned
    if (live && is_ld && !mis) begin
      e = (lat < int'(TMO)) ? lat : int'(TMO);
      if (fl_at >= 0 && fl_at < e) e = fl_at;
      if (fl_at == e) outcome = 0;
      else if (lat == e) outcome = 1;
      else outcome = 2;
    end else if (live) begin
      outcome = mis ? 3 : 1;
    end
    for (int k = 0; k <= e; k++) begin
      @(negedge clk);
      ex_valid = v; ex_alu = alu; ex_rd = rd; ex_regwr = regwr;
      ex_load = ld; ex_link = lnk; ex_pc8 = pc8;
      flush = (k == fl_at);
      mem_ready = is_ld ? (k >= lat) : 1'($urandom);
      mem_rdata = (is_ld && k < lat) ? $urandom : rdata;
      #1 check_eq("stall", 32'(stall), 32'(k < e));
      if (k < e) begin
        @(posedge clk);
        #1 check_eq("write_during_wait", 32'(write), 32'd0);
      end
    end
    @(posedge clk);
    #1;
    exp_write = 1'b0; exp_err = (outcome == 2); exp_mis = (outcome == 3);
    if (outcome == 1) begin
      m_rd = rd;
      m_wdata = lnk ? pc8 : (is_ld ? extract(ld, alu[1:0], rdata) : alu);
      exp_write = regwr && (rd != 5'd0);
      m_ret++;
    end else if (outcome == 3) begin
      m_ret++;
    end
    check_eq("write", 32'(write), 32'(exp_write));
    check_eq("reg_write", 32'(reg_write), 32'(m_rd));
    check_eq("wdata", wdata, m_wdata);
    check_eq("retired", retired, m_ret);
    check_eq("mem_err", 32'(mem_err), 32'(exp_err));
    check_eq("misalign", 32'(misalign), 32'(exp_mis));
  endtask

  initial begin
    logic [2:0] ld;
    int lat, fl;
    ex_valid = 0; ex_alu = 0; ex_rd = 0; ex_regwr = 0; ex_load = 0; ex_link = 0;
    ex_pc8 = 0; flush = 0; mem_rdata = 0; mem_ready = 0;
    m_rd = 0; m_wdata = 0; m_ret = 0;
    rst_n = 0;
    #12;
    check_outputs_zero("reset");
    check_eq("reset_stall", 32'(stall), 32'd0);
    @(negedge clk) rst_n = 1;

    do_instr(1, 32'h1234, 5'd8, 1, 3'd0, 0, 32'h0, 0, -1, 32'h0);          // ADDU
    do_instr(1, 32'h1003, 5'd9, 1, 3'd4, 0, 32'h0, 0, -1, 32'h80FF_FF7F);  // LB
    check_eq("lb_value", wdata, 32'hFFFF_FF80);
    do_instr(1, 32'h1000, 5'd10, 1, 3'd5, 0, 32'h0, 0, -1, 32'h80FF_FF7F); // LBU
    check_eq("lbu_value", wdata, 32'h0000_007F);
    do_instr(1, 32'h2002, 5'd11, 1, 3'd2, 0, 32'h0, 1, -1, 32'h8123_4567); // LH upper half
    do_instr(1, 32'h2000, 5'd12, 1, 3'd3, 0, 32'h0, 2, -1, 32'h4567_89AB); // LHU
    do_instr(1, 32'h3000, 5'd13, 1, 3'd1, 0, 32'h0, 3, -1, 32'hCAFE_F00D); // LW, 3-cycle wait
    do_instr(1, 32'h3000, 5'd14, 1, 3'd1, 0, 32'h0, 1000, -1, 32'h0);      // timeout
    do_instr(1, 32'h3002, 5'd15, 1, 3'd1, 0, 32'h0, 0, -1, 32'h0);         // misaligned LW
    do_instr(1, 32'h0055, 5'd0, 1, 3'd0, 0, 32'h0, 0, -1, 32'h0);          // rd=0
    do_instr(1, 32'h3004, 5'd16, 1, 3'd1, 0, 32'h0, 10, 2, 32'h0);         // flush in wait
    do_instr(1, 32'h0066, 5'd17, 1, 3'd0, 0, 32'h0, 0, 0, 32'h0);          // flush in RUN
    do_instr(0, 32'h0077, 5'd18, 1, 3'd0, 0, 32'h0, 0, -1, 32'h0);         // bubble
    do_instr(1, 32'h4001, 5'd19, 1, 3'd4, 1, 32'hBEEF_0008, 0, -1, 32'h0); // link wins

    for (int n = 0; n < 300; n++) begin
      ld  = 3'($urandom);
      lat = int'($urandom_range(0, 6));
      fl  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 2)) : -1;
      do_instr(1'($urandom_range(0, 7) != 0), $urandom, 5'($urandom), 1'($urandom), ld,
               ($urandom_range(0, 7) == 0), $urandom, lat, fl, $urandom);
    end

    // Reset while a load is waiting on memory
    @(negedge clk);
    ex_valid = 1; ex_load = 3'd1; ex_alu = 32'h5000; ex_rd = 5'd3; ex_regwr = 1;
    ex_link = 0; flush = 0; mem_ready = 0;
    @(negedge clk);
    #1 rst_n = 0; ex_valid = 0;
    #1 check_outputs_zero("mid_wait_reset");
    check_eq("mid_wait_reset_stall", 32'(stall), 32'd0);
    @(negedge clk) rst_n = 1;
    m_rd = 0; m_wdata = 0; m_ret = 0;
    do_instr(1, 32'h00AB, 5'd4, 1, 3'd0, 0, 32'h0, 0, -1, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
